// File: rtl/mem_arb_pkg.sv
// Shared state encoding, defaults and sizing helper for mem_arbiter_n.
package mem_arb_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_WDATA = 1'b1
  } arb_state_e;

  localparam int DEF_WR_BEATS   = 4;
  localparam int DEF_RESP_BEATS = 4;
  localparam int DEF_MAX_OUT    = 2;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// Find-first-set over N request bits starting at ptr and wrapping; pure combinational.
// Latency: zero; no backpressure (the caller qualifies the pick with its own ready).
module arb_rr_pick #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] idx,
  output logic         any
);

  logic [2*N-1:0] rot;

  // Doubling the vector lets a plain shift express the wrap-around.
  assign rot = {req, req} >> ptr;

  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        any = 1'b1;
        idx = W'((int'(ptr) + k) % N);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter_n.sv
// N-channel requester-to-memory arbiter with write grant lock and tag-routed responses; ARB_ROUND_ROBIN_EN selects rotating priority.
// Latency: zero (combinational request/response paths); backpressure: mem ready reaches only the granted channel.
`ifndef MEM_ADDR_BITS
`define MEM_ADDR_BITS 32
`endif
`ifndef MEM_TAG_BITS
`define MEM_TAG_BITS 8
`endif
`ifndef MEM_DATA_BITS
`define MEM_DATA_BITS 64
`endif

module mem_arbiter_n
  import mem_arb_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int ADDR_W     = `MEM_ADDR_BITS,
  parameter int TAG_W      = `MEM_TAG_BITS,
  parameter int DATA_W     = `MEM_DATA_BITS,
  parameter int WR_BEATS   = DEF_WR_BEATS,
  parameter int RESP_BEATS = DEF_RESP_BEATS,
  parameter int MAX_OUT    = DEF_MAX_OUT
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_CH-1:0]            ch_req_valid,
  output logic [NUM_CH-1:0]            ch_req_ready,
  input  logic [NUM_CH-1:0]            ch_req_rw,
  input  logic [NUM_CH*ADDR_W-1:0]     ch_req_addr,
  input  logic [NUM_CH-1:0]            ch_req_data_valid,
  output logic [NUM_CH-1:0]            ch_req_data_ready,
  input  logic [NUM_CH*DATA_W-1:0]     ch_req_data_bits,
  input  logic [NUM_CH*DATA_W/8-1:0]   ch_req_data_mask,
  output logic [NUM_CH-1:0]            ch_resp_valid,
  output logic                         mem_req_valid,
  input  logic                         mem_req_ready,
  output logic                         mem_req_rw,
  output logic [ADDR_W-1:0]            mem_req_addr,
  output logic [TAG_W-1:0]             mem_req_tag,
  output logic                         mem_req_data_valid,
  input  logic                         mem_req_data_ready,
  output logic [DATA_W-1:0]            mem_req_data_bits,
  output logic [DATA_W/8-1:0]          mem_req_data_mask,
  input  logic                         mem_resp_valid,
  input  logic [TAG_W-1:0]             mem_resp_tag,
  output logic                         err_bad_tag
);

  localparam int CH_W   = (clog2(NUM_CH) < 1) ? 1 : clog2(NUM_CH);
  localparam int MASK_W = DATA_W / 8;
  localparam int OC_W   = clog2(MAX_OUT + 1);
  localparam int BC_W   = (clog2(WR_BEATS) < 1) ? 1 : clog2(WR_BEATS);
  localparam int RC_W   = (clog2(RESP_BEATS) < 1) ? 1 : clog2(RESP_BEATS);

  arb_state_e        state, state_nxt;
  logic [CH_W-1:0]   ptr, lock, winner, resp_idx;
  logic [BC_W-1:0]   beat_cnt;
  logic [NUM_CH-1:0] elig, resp_hit, proto_err;
  logic              any_elig, accept, beat_acc, tag_ok;

  arb_rr_pick #(.N(NUM_CH), .W(CH_W)) u_pick (
    .req (elig),
    .ptr (ptr),
    .idx (winner),
    .any (any_elig)
  );

  assign accept   = (state == ARB_IDLE) & any_elig & mem_req_ready;
  assign beat_acc = (state == ARB_WDATA) & ch_req_data_valid[lock] & mem_req_data_ready;

  assign resp_idx = mem_resp_tag[CH_W-1:0];
  assign tag_ok   = ((mem_resp_tag >> CH_W) == '0) && (int'(resp_idx) < NUM_CH);

  always_comb begin
    state_nxt          = state;
    mem_req_valid      = 1'b0;
    mem_req_rw         = ch_req_rw[winner];
    mem_req_addr       = ch_req_addr[winner*ADDR_W +: ADDR_W];
    mem_req_tag        = '0;
    mem_req_tag[CH_W-1:0] = winner;
    mem_req_data_valid = 1'b0;
    mem_req_data_bits  = ch_req_data_bits[lock*DATA_W +: DATA_W];
    mem_req_data_mask  = ch_req_data_mask[lock*MASK_W +: MASK_W];
    ch_req_ready       = '0;
    ch_req_data_ready  = '0;
    case (state)
      ARB_IDLE: begin
        mem_req_valid        = any_elig;
        ch_req_ready[winner] = any_elig & mem_req_ready;
        if (accept && ch_req_rw[winner]) state_nxt = ARB_WDATA;
      end
      ARB_WDATA: begin
        mem_req_data_valid      = ch_req_data_valid[lock];
        ch_req_data_ready[lock] = mem_req_data_ready;
        if (beat_acc && beat_cnt == BC_W'(WR_BEATS - 1)) state_nxt = ARB_IDLE;
      end
      default: state_nxt = ARB_IDLE;
    endcase
    if (reset) begin
      mem_req_valid      = 1'b0;
      mem_req_data_valid = 1'b0;
      ch_req_ready       = '0;
      ch_req_data_ready  = '0;
    end
  end

  assign ch_resp_valid = resp_hit & {NUM_CH{~reset}};

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [OC_W-1:0] out_cnt;
    logic [RC_W-1:0] resp_cnt;
    logic            rd_inc, rd_fin;

    assign resp_hit[g]  = mem_resp_valid & tag_ok & (resp_idx == CH_W'(g));
    assign rd_inc       = accept & (winner == CH_W'(g)) & ~ch_req_rw[g];
    assign rd_fin       = resp_hit[g] & (resp_cnt == RC_W'(RESP_BEATS - 1));
    assign elig[g]      = ch_req_valid[g] & (ch_req_rw[g] | (out_cnt < OC_W'(MAX_OUT)));
    assign proto_err[g] = rd_fin & (out_cnt == '0);

    always_ff @(posedge clk) begin
      if (reset) begin
        out_cnt  <= '0;
        resp_cnt <= '0;
      end else begin
        if (resp_hit[g]) resp_cnt <= rd_fin ? '0 : resp_cnt + 1'b1;
        // A grant and a completion in the same cycle cancel out.
        if (rd_inc && !rd_fin) out_cnt <= out_cnt + 1'b1;
        else if (rd_fin && !rd_inc && out_cnt != '0) out_cnt <= out_cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ARB_IDLE;
      lock        <= '0;
      beat_cnt    <= '0;
      err_bad_tag <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept && ch_req_rw[winner]) begin
        lock     <= winner;
        beat_cnt <= '0;
      end else if (beat_acc) begin
        beat_cnt <= beat_cnt + 1'b1;
      end
      if ((mem_resp_valid && !tag_ok) || (|proto_err)) err_bad_tag <= 1'b1;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk) begin
    if (reset) ptr <= '0;
    else if (accept) ptr <= (int'(winner) == NUM_CH - 1) ? '0 : winner + 1'b1;
  end
`else
  assign ptr = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter_n.sv
// Directed scenarios plus random traffic for mem_arbiter_n, checked against a transaction-level model.
module tb_mem_arbiter_n;

  localparam int NCH = 4;
  localparam int AW  = 16;
  localparam int TW  = 4;
  localparam int DW  = 32;
  localparam int MW  = DW / 8;
  localparam int WB  = 4;
  localparam int RB  = 4;
  localparam int MO  = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [NCH-1:0]    ch_req_valid, ch_req_ready, ch_req_rw;
  logic [NCH*AW-1:0] ch_req_addr;
  logic [NCH-1:0]    ch_req_data_valid, ch_req_data_ready, ch_resp_valid;
  logic [NCH*DW-1:0] ch_req_data_bits;
  logic [NCH*MW-1:0] ch_req_data_mask;
  logic              mem_req_valid, mem_req_ready, mem_req_rw;
  logic [AW-1:0]     mem_req_addr;
  logic [TW-1:0]     mem_req_tag;
  logic              mem_req_data_valid, mem_req_data_ready;
  logic [DW-1:0]     mem_req_data_bits;
  logic [MW-1:0]     mem_req_data_mask;
  logic              mem_resp_valid;
  logic [TW-1:0]     mem_resp_tag;
  logic              err_bad_tag;

  int total = 0;
  int bad   = 0;

  // Reference model: pending-read counts, response beats seen, burst progress.
  int m_ptr, m_lock, m_done;
  bit m_burst, m_err;
  int m_out [NCH];
  int m_rc  [NCH];

  bit         wr_rdy_pat [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
  logic [3:0] mask_tab   [4] = '{4'hF, 4'h3, 4'hC, 4'h5};
`ifdef ARB_ROUND_ROBIN_EN
  int exp_order [5] = '{0, 1, 2, 3, 0};
`else
  int exp_order [5] = '{0, 0, 1, 1, 2};
`endif

  always #5 clk = ~clk;

  mem_arbiter_n #(
    .NUM_CH(NCH), .ADDR_W(AW), .TAG_W(TW), .DATA_W(DW),
    .WR_BEATS(WB), .RESP_BEATS(RB), .MAX_OUT(MO)
  ) dut (
    .clk(clk), .reset(reset),
    .ch_req_valid(ch_req_valid), .ch_req_ready(ch_req_ready), .ch_req_rw(ch_req_rw),
    .ch_req_addr(ch_req_addr),
    .ch_req_data_valid(ch_req_data_valid), .ch_req_data_ready(ch_req_data_ready),
    .ch_req_data_bits(ch_req_data_bits), .ch_req_data_mask(ch_req_data_mask),
    .ch_resp_valid(ch_resp_valid),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_rw(mem_req_rw),
    .mem_req_addr(mem_req_addr), .mem_req_tag(mem_req_tag),
    .mem_req_data_valid(mem_req_data_valid), .mem_req_data_ready(mem_req_data_ready),
    .mem_req_data_bits(mem_req_data_bits), .mem_req_data_mask(mem_req_data_mask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_tag(mem_resp_tag),
    .err_bad_tag(err_bad_tag)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_lock = 0; m_done = 0; m_burst = 1'b0; m_err = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      m_out[c] = 0;
      m_rc[c]  = 0;
    end
  endtask

  function automatic int model_winner();
    int c;
    for (int k = 0; k < NCH; k++) begin
      c = (m_ptr + k) % NCH;
      if (ch_req_valid[c] && (ch_req_rw[c] || m_out[c] < MO)) return c;
    end
    return -1;
  endfunction

  task automatic check_outputs();
    int w;
    logic e_vld, e_dvld;
    logic [NCH-1:0] e_rdy, e_drdy, e_resp;
    w = model_winner();
    e_vld  = !reset && !m_burst && (w >= 0);
    e_rdy  = '0;
    if (e_vld && mem_req_ready) e_rdy[w] = 1'b1;
    e_dvld = !reset && m_burst && ch_req_data_valid[m_lock];
    e_drdy = '0;
    if (!reset && m_burst && mem_req_data_ready) e_drdy[m_lock] = 1'b1;
    e_resp = '0;
    if (!reset && mem_resp_valid && int'(mem_resp_tag) < NCH) e_resp[mem_resp_tag] = 1'b1;
    chk("mem_req_valid", mem_req_valid, e_vld);
    chk("ch_req_ready", ch_req_ready, e_rdy);
    if (e_vld) begin
      chk("mem_req_tag", mem_req_tag, w);
      chk("mem_req_addr", mem_req_addr, ch_req_addr[w*AW +: AW]);
      chk("mem_req_rw", mem_req_rw, ch_req_rw[w]);
    end
    chk("mem_req_data_valid", mem_req_data_valid, e_dvld);
    chk("ch_req_data_ready", ch_req_data_ready, e_drdy);
    if (e_dvld) begin
      chk("mem_req_data_bits", mem_req_data_bits, ch_req_data_bits[m_lock*DW +: DW]);
      chk("mem_req_data_mask", mem_req_data_mask, ch_req_data_mask[m_lock*MW +: MW]);
    end
    chk("ch_resp_valid", ch_resp_valid, e_resp);
    chk("err_bad_tag", err_bad_tag, m_err);
  endtask

  task automatic model_update();
    int w, rd, fin, t;
    if (reset) begin
      model_reset();
      return;
    end
    w = model_winner();
    rd = -1;
    fin = -1;
    if (m_burst) begin
      if (ch_req_data_valid[m_lock] && mem_req_data_ready) begin
        m_done++;
        if (m_done == WB) m_burst = 1'b0;
      end
    end else if (w >= 0 && mem_req_ready) begin
      if (ch_req_rw[w]) begin
        m_burst = 1'b1; m_lock = w; m_done = 0;
      end else begin
        rd = w;
      end
`ifdef ARB_ROUND_ROBIN_EN
      m_ptr = (w + 1) % NCH;
`endif
    end
    if (mem_resp_valid) begin
      t = int'(mem_resp_tag);
      if (t >= NCH) m_err = 1'b1;
      else begin
        m_rc[t]++;
        if (m_rc[t] == RB) begin
          m_rc[t] = 0;
          fin = t;
        end
      end
    end
    for (int c = 0; c < NCH; c++) begin
      if (c == fin && m_out[c] == 0) m_err = 1'b1;
      if (c == rd && c == fin) begin
      end else if (c == rd) m_out[c]++;
      else if (c == fin && m_out[c] > 0) m_out[c]--;
    end
  endtask

  task automatic settle();
    #1;
    check_outputs();
  endtask

  task automatic tick();
    model_update();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    ch_req_valid = '0; ch_req_rw = '0; ch_req_addr = '0;
    ch_req_data_valid = '0; ch_req_data_bits = '0; ch_req_data_mask = '0;
    mem_req_ready = 1'b1; mem_req_data_ready = 1'b1;
    mem_resp_valid = 1'b0; mem_resp_tag = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    settle();
    tick();
    reset = 1'b0;
  endtask

  task automatic send_resp(input int ch, input int n);
    logic [NCH-1:0] e;
    e = '0;
    e[ch] = 1'b1;
    for (int b = 0; b < n; b++) begin
      mem_resp_valid = 1'b1;
      mem_resp_tag   = TW'(ch);
      settle();
      chk("resp_route", ch_resp_valid, e);
      tick();
    end
    mem_resp_valid = 1'b0;
  endtask

  initial begin
    int beat;
    int cand[$];
    model_reset();
    idle_inputs();
    ch_req_valid = '1;
    @(posedge clk);
    @(negedge clk);
    settle();
    chk("rst_mem_req_valid", mem_req_valid, 1'b0);
    chk("rst_ch_req_ready", ch_req_ready, 4'h0);
    chk("rst_err", err_bad_tag, 1'b0);
    tick();
    reset = 1'b0;
    idle_inputs();

    // Single read on ch0, then its four response beats.
    ch_req_valid = 4'b0001;
    ch_req_addr[0 +: AW] = 16'h0100;
    settle();
    chk("rd_tag", mem_req_tag, 0);
    chk("rd_addr", mem_req_addr, 16'h0100);
    tick();
    ch_req_valid = '0;
    send_resp(0, RB);

    // Write burst on ch1 while ch0 holds a read.
    ch_req_valid = 4'b0010;
    ch_req_rw    = 4'b0010;
    ch_req_addr[AW +: AW] = 16'h0200;
    settle();
    chk("wr_grant_tag", mem_req_tag, 1);
    chk("wr_grant_rw", mem_req_rw, 1'b1);
    tick();
    ch_req_valid = 4'b0001;
    ch_req_rw    = '0;
    ch_req_addr[0 +: AW] = 16'h0300;
    ch_req_data_valid = 4'b0010;
    beat = 0;
    for (int i = 0; i < 5; i++) begin
      mem_req_data_ready = wr_rdy_pat[i];
      ch_req_data_bits[DW +: DW] = 32'hA5A5_0000 + 32'(beat);
      ch_req_data_mask[MW +: MW] = mask_tab[beat];
      settle();
      chk("wr_rd_blocked", mem_req_valid, 1'b0);
      chk("wr_data", mem_req_data_bits, 32'hA5A5_0000 + 32'(beat));
      chk("wr_mask", mem_req_data_mask, mask_tab[beat]);
      tick();
      if (wr_rdy_pat[i]) beat++;
    end
    ch_req_data_valid  = '0;
    mem_req_data_ready = 1'b1;
    settle();
    chk("rd_after_wr_vld", mem_req_valid, 1'b1);
    chk("rd_after_wr_tag", mem_req_tag, 0);
    tick();
    ch_req_valid = '0;
    send_resp(0, RB);

    // Third back-to-back read waits for the first read to complete.
    ch_req_valid = 4'b0001;
    ch_req_addr[0 +: AW] = 16'h0400;
    for (int i = 0; i < 2; i++) begin
      settle();
      chk("thr_accept", ch_req_ready[0], 1'b1);
      tick();
    end
    settle();
    chk("thr_hold", ch_req_ready[0], 1'b0);
    tick();
    for (int b = 0; b < RB; b++) begin
      mem_resp_valid = 1'b1;
      mem_resp_tag   = '0;
      settle();
      chk("thr_hold_beat", ch_req_ready[0], 1'b0);
      tick();
    end
    mem_resp_valid = 1'b0;
    settle();
    chk("thr_release", ch_req_ready[0], 1'b1);
    tick();
    ch_req_valid = '0;
    send_resp(0, 2 * RB);

    // Grant order with every channel requesting reads.
    do_reset();
    ch_req_valid = '1;
    for (int c = 0; c < NCH; c++) ch_req_addr[c*AW +: AW] = 16'h1000 + 16'(c);
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("grant_order", mem_req_tag, exp_order[i]);
      tick();
    end
    do_reset();

    // Out-of-range response tag.
    mem_resp_valid = 1'b1;
    mem_resp_tag   = 4'd5;
    settle();
    chk("bad_tag_drop", ch_resp_valid, 4'h0);
    tick();
    mem_resp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("bad_tag_sticky", err_bad_tag, 1'b1);
      tick();
    end
    do_reset();
    settle();
    chk("bad_tag_cleared", err_bad_tag, 1'b0);
    tick();

    // Reset after two beats of a write burst.
    ch_req_valid = 4'b0100;
    ch_req_rw    = 4'b0100;
    settle();
    tick();
    ch_req_valid = '0;
    ch_req_rw    = '0;
    ch_req_data_valid = 4'b0100;
    for (int i = 0; i < 2; i++) begin
      settle();
      tick();
    end
    reset = 1'b1;
    settle();
    chk("rst_mid_dvld", mem_req_data_valid, 1'b0);
    chk("rst_mid_drdy", ch_req_data_ready, 4'h0);
    tick();
    reset = 1'b0;
    ch_req_valid = 4'b1000;
    ch_req_addr[3*AW +: AW] = 16'h0BEE;
    settle();
    chk("post_rst_vld", mem_req_valid, 1'b1);
    chk("post_rst_tag", mem_req_tag, 3);
    chk("post_rst_dvld", mem_req_data_valid, 1'b0);
    tick();
    idle_inputs();

    // Random traffic against the model.
    for (int cyc = 0; cyc < 600; cyc++) begin
      ch_req_valid       = NCH'($urandom);
      ch_req_rw          = ($urandom_range(0, 5) == 0) ? NCH'($urandom) : '0;
      ch_req_addr        = {$urandom, $urandom};
      ch_req_data_valid  = NCH'($urandom);
      ch_req_data_bits   = {$urandom, $urandom, $urandom, $urandom};
      ch_req_data_mask   = 16'($urandom);
      mem_req_ready      = ($urandom_range(0, 3) != 0);
      mem_req_data_ready = ($urandom_range(0, 3) != 0);
      cand.delete();
      for (int c = 0; c < NCH; c++) if (m_out[c] > 0) cand.push_back(c);
      mem_resp_valid = 1'b0;
      mem_resp_tag   = '0;
      if (cand.size() > 0 && $urandom_range(0, 1) == 1) begin
        mem_resp_valid = 1'b1;
        mem_resp_tag   = TW'(cand[$urandom_range(0, cand.size() - 1)]);
      end
      settle();
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
